// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester, response and memory-port signals of the arbiter
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req_valid;
  logic [ADDR_W-1:0] if_addr;
  logic              if_req_ready;
  logic              if_rsp_valid;
  logic [DATA_W-1:0] if_rsp_data;
  logic              d_req_valid;
  logic [ADDR_W-1:0] d_addr;
  logic              d_we;
  logic [DATA_W-1:0] d_wdata;
  logic              d_req_ready;
  logic              d_rsp_valid;
  logic [DATA_W-1:0] d_rsp_data;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;
  modport slave (
    input  if_req_valid, if_addr, d_req_valid, d_addr, d_we, d_wdata, mem_rdata,
    output if_req_ready, if_rsp_valid, if_rsp_data, d_req_ready, d_rsp_valid, d_rsp_data,
           mem_en, mem_we, mem_addr, mem_wdata, busy
  );
  modport master (
    output if_req_valid, if_addr, d_req_valid, d_addr, d_we, d_wdata, mem_rdata,
    input  if_req_ready, if_rsp_valid, if_rsp_data, d_req_ready, d_rsp_valid, d_rsp_data,
           mem_en, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: fetch/data arbiter onto a single fixed-latency memory port
module mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MEM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input logic          clk,
  input logic          reset_n,
  mem_arbiter_if.slave bus
);
  typedef enum logic {IDLE, WAIT} state_t;
  localparam logic [2:0] LAT = 3'(MEM_LATENCY);
  localparam logic [3:0] LIM = 4'(STARVE_LIMIT);
  state_t     state;
  logic [2:0] lat;
  logic [3:0] starve;
  logic       sel_d;
  logic       is_store;
  logic       grant_f;
  logic       grant_d;
  logic       resp;
  // grant decision: data first unless fetch has waited STARVE_LIMIT data grants
  always_comb begin
    grant_f = state == IDLE && bus.if_req_valid && (!bus.d_req_valid || starve == LIM);
    grant_d = state == IDLE && bus.d_req_valid && !grant_f;
    resp    = state == WAIT && lat == LAT;
  end
  assign bus.if_req_ready = grant_f;
  assign bus.d_req_ready  = grant_d;
  assign bus.mem_en       = grant_f | grant_d;
  assign bus.mem_we       = grant_d & bus.d_we;
  assign bus.mem_addr     = grant_d ? bus.d_addr : grant_f ? bus.if_addr : ADDR_W'(0);
  assign bus.mem_wdata    = grant_d ? bus.d_wdata : DATA_W'(0);
  assign bus.if_rsp_valid = resp & ~sel_d;
  assign bus.d_rsp_valid  = resp & sel_d;
  assign bus.if_rsp_data  = bus.if_rsp_valid ? bus.mem_rdata : DATA_W'(0);
  assign bus.d_rsp_data   = bus.d_rsp_valid && !is_store ? bus.mem_rdata : DATA_W'(0);
  assign bus.busy         = state == WAIT;
  // accept one access, count its latency, and track fetch starvation
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      lat      <= '0;
      starve   <= '0;
      sel_d    <= 1'b0;
      is_store <= 1'b0;
    end else if (state == IDLE) begin
      if (grant_f || grant_d) begin
        state    <= WAIT;
        lat      <= 3'd1;
        sel_d    <= grant_d;
        is_store <= grant_d & bus.d_we;
      end
      if (grant_f)
        starve <= '0;
      else if (grant_d && bus.if_req_valid && starve != LIM)
        starve <= starve + 4'd1;
    end else if (resp) begin
      state    <= IDLE;
      lat      <= '0;
      sel_d    <= 1'b0;
      is_store <= 1'b0;
    end else begin
      lat <= lat + 3'd1;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of the arbiter at latency 1 (a) and latency 3 (b)
module tb_mem_arbiter;
  localparam logic [31:0] RD = 32'h0050_0093;
  logic clk = 1'b0;
  logic rn1 = 1'b0;
  logic rn3 = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;
  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) a ();
  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b ();
  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1), .STARVE_LIMIT(4)) u_a (
    .clk(clk), .reset_n(rn1), .bus(a.slave));
  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(3), .STARVE_LIMIT(4)) u_b (
    .clk(clk), .reset_n(rn3), .bus(b.slave));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  // control/status view: mem_en, mem_we, if_ready, d_ready, if_rsp, d_rsp, busy
  function automatic logic [6:0] ctl_a();
    return {a.mem_en, a.mem_we, a.if_req_ready, a.d_req_ready, a.if_rsp_valid, a.d_rsp_valid, a.busy};
  endfunction
  function automatic logic [6:0] ctl_b();
    return {b.mem_en, b.mem_we, b.if_req_ready, b.d_req_ready, b.if_rsp_valid, b.d_rsp_valid, b.busy};
  endfunction
  initial begin
    a.if_req_valid = 0; a.if_addr = 0; a.d_req_valid = 0; a.d_addr = 0; a.d_we = 0; a.d_wdata = 0; a.mem_rdata = RD;
    b.if_req_valid = 0; b.if_addr = 0; b.d_req_valid = 0; b.d_addr = 0; b.d_we = 0; b.d_wdata = 0; b.mem_rdata = RD;
    #2;
    chk("reset_ctl_a", 64'(ctl_a()), 64'h0);
    chk("reset_ctl_b", 64'(ctl_b()), 64'h0);
    chk("reset_data_a", {a.if_rsp_data, a.d_rsp_data}, 64'h0);
    step();
    rn1 = 1; rn3 = 1;
    // fetch only, latency 1
    step();
    a.if_req_valid = 1; a.if_addr = 32'h10;
    #1;
    chk("f_accept", 64'(ctl_a()), 64'b1010000);
    chk("f_addr", 64'(a.mem_addr), 64'h10);
    step();
    chk("f_rsp", 64'(ctl_a()), 64'b0000101);
    chk("f_rsp_data", 64'(a.if_rsp_data), 64'(RD));
    step();
    chk("f_next_accept", 64'(a.if_req_ready), 64'h1);
    a.if_req_valid = 0;
    // simultaneous requests, data store wins
    step();
    a.if_req_valid = 1; a.if_addr = 32'h20;
    a.d_req_valid = 1; a.d_we = 1; a.d_addr = 32'h80; a.d_wdata = 32'hDEAD_BEEF;
    #1;
    chk("d_accept", 64'(ctl_a()), 64'b1101000);
    chk("d_addr", 64'(a.mem_addr), 64'h80);
    chk("d_wdata", 64'(a.mem_wdata), 64'hDEAD_BEEF);
    step();
    chk("d_rsp", 64'(ctl_a()), 64'b0000011);
    chk("d_rsp_store_data", {a.d_rsp_data, a.if_rsp_data}, 64'h0);
    a.d_req_valid = 0; a.d_we = 0;
    step();
    chk("f_after_d", 64'(ctl_a()), 64'b1010000);
    chk("f_after_d_we", 64'(a.mem_wdata), 64'h0);
    step();
    chk("f_after_d_rsp", 64'(a.if_rsp_data), 64'(RD));
    a.if_req_valid = 0;
    // starvation pattern: 4 data grants then 1 fetch, repeated
    step();
    a.if_req_valid = 1; a.d_req_valid = 1; a.d_addr = 32'h90;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk($sformatf("starve_grant%0d", i), {a.if_req_ready, a.d_req_ready}, (i % 5 == 4) ? 64'b10 : 64'b01);
      step();
      if (i == 0) chk("starve_load_data", 64'(a.d_rsp_data), 64'(RD));
      step();
    end
    a.if_req_valid = 0; a.d_req_valid = 0;
    // idle for 20 cycles
    for (int i = 0; i < 20; i++) begin
      step();
      chk($sformatf("idle%0d", i), 64'(ctl_a()), 64'h0);
    end
    // latency 3 load
    step();
    b.d_req_valid = 1; b.d_we = 0; b.d_addr = 32'h40;
    #1;
    chk("l3_accept", 64'(ctl_b()), 64'b1001000);
    for (int k = 1; k <= 3; k++) begin
      step();
      b.d_req_valid = 0; b.if_req_valid = 1; b.if_addr = 32'h44;
      #1;
      chk($sformatf("l3_wait%0d", k), 64'(ctl_b()), (k == 3) ? 64'b0000011 : 64'b0000001);
      chk($sformatf("l3_data%0d", k), 64'(b.d_rsp_data), (k == 3) ? 64'(RD) : 64'h0);
    end
    step();
    chk("l3_reaccept", 64'(ctl_b()), 64'b1010000);
    b.if_req_valid = 0;
    step();
    step();
    step();
    step();
    // reset in the middle of an outstanding fetch
    step();
    b.if_req_valid = 1; b.if_addr = 32'h30;
    #1;
    chk("rst_accept", 64'(b.if_req_ready), 64'h1);
    step();
    b.if_req_valid = 0;
    chk("rst_pre_busy", 64'(b.busy), 64'h1);
    rn3 = 0;
    #1;
    chk("rst_async", 64'(ctl_b()), 64'h0);
    step();
    rn3 = 1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("rst_no_rsp%0d", k), 64'(ctl_b()), 64'h0);
    end
    step();
    b.d_req_valid = 1; b.d_addr = 32'h50;
    #1;
    chk("rst_first_grant", 64'(ctl_b()), 64'b1001000);
    step();
    b.d_req_valid = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, address width of both requesters and the memory port.
REQ-002 Parameter DATA_W, default 32, data width of all data paths.
REQ-003 Parameter MEM_LATENCY, default 1, cycles from mem_en to valid mem_rdata; legal range 1..7.
REQ-004 Parameter STARVE_LIMIT, default 4, consecutive data grants tolerated while fetch is pending; legal range 1..15.
REQ-005 clk  input  1  sole clock; all state updates on the rising edge.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 if_req_valid  input  1  fetch requester has a read pending.
REQ-008 if_addr  input  ADDR_W  fetch address; stable while if_req_valid=1.
REQ-009 if_req_ready  output  1  fetch request accepted this cycle.
REQ-010 if_rsp_valid  output  1  one-cycle pulse, fetch read data valid.
REQ-011 if_rsp_data  output  DATA_W  fetch read data.
REQ-012 d_req_valid  input  1  load/store requester has an access pending.
REQ-013 d_addr / d_we / d_wdata  input  ADDR_W / 1 / DATA_W  data address, write enable, write data; stable while d_req_valid=1.
REQ-014 d_req_ready  output  1  data request accepted this cycle.
REQ-015 d_rsp_valid  output  1  one-cycle pulse, load data valid or store complete.
REQ-016 d_rsp_data  output  DATA_W  load data; 0 for stores.
REQ-017 mem_en / mem_we  output  1 / 1  memory access strobe and write enable.
REQ-018 mem_addr / mem_wdata  output  ADDR_W / DATA_W  memory address and write data.
REQ-019 mem_rdata  input  DATA_W  memory read data, valid MEM_LATENCY cycles after mem_en.
REQ-020 busy  output  1  1 while an access is outstanding (state WAIT).

Function
REQ-021 Two states: IDLE, WAIT; exactly one access outstanding at any time.
REQ-022 In IDLE with at least one valid request, the arbiter grants one requester in the same cycle: grantee ready=1, mem_en=1, mem_addr/mem_we/mem_wdata driven combinationally from the grantee; transition to WAIT.
REQ-023 In IDLE with no valid request: both ready=0, mem_en=0, mem_we=0, stay IDLE.
REQ-024 Priority: data over fetch, except fetch wins when starve_cnt == STARVE_LIMIT.
REQ-025 starve_cnt increments (saturating at STARVE_LIMIT) on every data grant while if_req_valid=1, clears on every fetch grant, and otherwise holds.
REQ-026 Fetch grants always drive mem_we=0; data grants drive mem_we=d_we and mem_wdata=d_wdata.
REQ-027 WAIT holds a latency counter; with accept at cycle T, the grantee's rsp_valid=1 in cycle T+MEM_LATENCY only, and rsp_data=mem_rdata in that cycle (d_rsp_data=0 for stores).
REQ-028 The FSM returns to IDLE at T+MEM_LATENCY+1; no request is accepted during WAIT, including the response cycle; the maximum rate is one access per MEM_LATENCY+1 cycles.
REQ-029 In WAIT: mem_en=0, both ready=0, busy=1; the non-responding rsp_valid=0.
REQ-030 The arbiter latches the grantee identity and the store flag at acceptance; requester inputs are ignored during WAIT.
REQ-031 rsp_data outputs are 0 whenever the corresponding rsp_valid=0.

Reset
REQ-032 reset_n=0 asynchronously forces: state IDLE, starve_cnt 0, latency counter 0, grantee cleared; all ready/rsp_valid/mem_en/mem_we/busy = 0, rsp_data = 0.
REQ-033 Reset during WAIT drops the outstanding access: no rsp_valid is produced for it after reset release.
REQ-034 After reset_n rises, the first grant can occur in the first clock edge cycle with a valid request.

Verification
REQ-035 Fetch only, MEM_LATENCY=1, if_addr=0x10, mem_rdata=0x00500093 at T+1 -> if_req_ready=1 and mem_en=1 at T, if_rsp_valid=1 with data 0x00500093 at T+1, next accept at T+2.
REQ-036 Simultaneous if/d valid in IDLE, d_we=1, d_addr=0x80, d_wdata=0xDEADBEEF -> d_req_ready=1, mem_we=1, mem_wdata=0xDEADBEEF; d_rsp_valid=1 at T+1 with d_rsp_data=0; fetch granted at T+2.
REQ-037 Starvation, STARVE_LIMIT=4: if_req_valid and d_req_valid held high continuously -> 4 data grants, then a fetch grant, then the pattern repeats; starve_cnt never exceeds 4.
REQ-038 MEM_LATENCY=3, data load accepted at T -> busy=1 for T+1..T+3, d_rsp_valid only at T+3, no ready asserted in T+1..T+3.
REQ-039 reset_n pulsed low at T+1 after a fetch accept at T (MEM_LATENCY=3) -> outputs 0 immediately, no if_rsp_valid at any later cycle, and a new request is granted on the first valid cycle after release.
REQ-040 Idle bench with no valid requests for 20 cycles -> mem_en, both ready, both rsp_valid and busy all remain 0.
